// File: rtl/usr_shift_sequencer.sv
// -----------------------------------------------------------------------------
// usr_shift_sequencer
//
// Command-driven controller and state register for a reversible universal
// shift register. One command at a time is accepted over a valid/ready
// handshake (hold, shift right, shift left, parallel load). Multi-step shifts
// advance the register once per clock for the programmed count, and a
// one-cycle done pulse marks completion.
//
// Optional build macro:
//   USR_ROTATE_EN - when defined, shifts rotate (the bit leaving one end
//                   re-enters at the other) and sin_r/sin_l are ignored.
//                   When undefined, shifts fill from sin_r/sin_l.
//
// Parameters:
//   WIDTH - register width in bits (minimum 2)
//   CW    - shift-count width (up to 2^CW-1 steps per command)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  block can accept a command (IDLE only)
//   cmd_op     in   00 hold, 01 shift right, 10 shift left, 11 load
//   cmd_count  in   number of shift steps (ignored for hold/load)
//   cmd_data   in   parallel load value
//   sin_r      in   serial input entering MSB on right shift
//   sin_l      in   serial input entering LSB on left shift
//   q          out  register contents
//   sout       out  last bit shifted out
//   busy       out  command in progress (LOAD or SHIFT)
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module usr_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             left_q, left_d;

  // Bits entering the vacated end on a shift: the serial inputs, or the bit
  // leaving the opposite end when the register is built as a rotator.
  logic fill_r, fill_l;

  always_comb begin
`ifdef USR_ROTATE_EN
    fill_r = q_q[0];
    fill_l = q_q[WIDTH-1];
`else
    fill_r = sin_r;
    fill_l = sin_l;
`endif
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    data_d  = data_q;
    sout_d  = sout_q;
    rem_d   = rem_q;
    left_d  = left_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Capture everything at accept so the source may move on.
          data_d = cmd_data;
          left_d = (cmd_op == OP_SHL);
          rem_d  = cmd_count;
          if (cmd_op == OP_LOAD) begin
            state_d = S_LOAD;
          end else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) &&
                       (cmd_count != '0)) begin
            state_d = S_SHIFT;
          end else begin
            // Hold, or a shift of zero steps: nothing to do but report done.
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        q_d     = data_q;
        state_d = S_DONE;
      end

      S_SHIFT: begin
        // The direction bit picks which neighbour feeds each bit position,
        // mirroring a controlled-swap selection.
        if (left_q) begin
          q_d    = {q_q[WIDTH-2:0], fill_l};
          sout_d = q_q[WIDTH-1];
        end else begin
          q_d    = {fill_r, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        rem_d = rem_q - COUNT_ONE;
        if (rem_q == COUNT_ONE) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      rem_q   <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign q         = q_q;
  assign sout      = sout_q;

  // The hold opcode has no dedicated datapath; it is named for readability.
  logic unused_op_hold;
  assign unused_op_hold = (OP_HOLD == 2'b00);

endmodule
